regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port (write/wrReg/wrData) between two
//   writeback requesters: A = ALU/execute result, B = memory-load result.
//   Round-robin arbitration with valid/ready handshakes; one registered output stage
//   drives the register-file write port. Writes to $0 are dropped (optional).
//   Provides a saturating conflict counter for performance monitoring.
// PARAMETERS
//   DATA_W     32  width of write data
//   ADDR_W     5   width of register address
//   DROP_ZERO  1   1: accept but suppress writes to address 0; 0: pass them through
//   CNT_W      16  width of conflict counter
// PORTS
//   clk           in   1       clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   a_valid       in   1       requester A has a write pending
//   a_ready       out  1       A's write accepted this cycle (comb.)
//   a_addr        in   ADDR_W  A destination register
//   a_data        in   DATA_W  A write data
//   b_valid       in   1       requester B has a write pending
//   b_ready       out  1       B's write accepted this cycle (comb.)
//   b_addr        in   ADDR_W  B destination register
//   b_data        in   DATA_W  B write data
//   wr_en         out  1       register-file write enable (registered)
//   wr_addr       out  ADDR_W  register-file write address (registered)
//   wr_data       out  DATA_W  register-file write data (registered)
//   conflict_cnt  out  CNT_W   cycles with a_valid & b_valid, saturating
// BEHAVIOUR
//   - Reset (rst_n=0, async): wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0,
//     priority pointer = A. a_ready/b_ready are 0 while rst_n=0.
//   - One clock, one domain. Every cycle exactly one grant at most.
//   - Grant (comb.): only A valid -> A; only B valid -> B; both -> side named by the
//     pointer. Neither valid -> no grant. ready = grant for that side.
//   - Handshake: transfer when valid & ready at a rising edge. Requester holds
//     valid/addr/data stable until ready; valid may drop only after transfer.
//     Arbiter never depends on ready to compute valid (no comb. loops).
//   - Pointer: on a transfer while both valid, pointer moves to the losing side.
//     Single-requester transfers leave the pointer unchanged. Worst-case wait for
//     a continuously valid requester = 1 cycle.
//   - Output stage: on transfer at edge N, wr_en=1 with that addr/data during
//     cycle N..N+1 (write lands in the register file at edge N+1). No transfer ->
//     wr_en=0 next cycle; wr_addr/wr_data hold their last values.
//   - No backpressure from the register file: one write per cycle always drains,
//     so back-to-back transfers give wr_en high on consecutive cycles.
//   - DROP_ZERO=1 and granted addr==0: ready still asserted (request retired),
//     wr_en=0 next cycle, pointer updated as for a normal grant.
//   - Same-address A and B in one cycle: only the granted one is written; the
//     loser is written the next cycle (last writer wins in the regfile).
//   - conflict_cnt: +1 each cycle with a_valid & b_valid; stops at 2^CNT_W-1.
//   - Reset asserted mid-operation: pending output write discarded (wr_en forced 0
//     immediately); requesters must re-present after rst_n releases.
// TESTING
//   1. Reset: rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, wr_en=0,
//      conflict_cnt=0; release -> first grant goes to A.
//   2. A only, addr=5 data=0xDEADBEEF -> a_ready=1 same cycle; next cycle wr_en=1,
//      wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_en=0.
//   3. A and B valid 4 cycles (fresh data each) -> grants A,B,A,B; wr_en high 4
//      consecutive cycles; conflict_cnt=4.
//   4. DROP_ZERO=1, B addr=0 data=0x1234 -> b_ready=1, wr_en stays 0; repeat with
//      DROP_ZERO=0 -> wr_en=1, wr_addr=0.
//   5. Both valid, both addr=7 (A=0x11, B=0x22), pointer=A -> wr_data 0x11 then
//      0x22 on consecutive cycles; regfile ends with 0x22.
//   6. CNT_W=4, both valid 20 cycles -> conflict_cnt saturates at 15; async rst_n
//      pulse mid-cycle with wr_en=1 -> wr_en and conflict_cnt drop to 0 at once.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = execute, B = load) and the
// arbiter, plus the registered register-file write port and the conflict counter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  conflict_cnt;

  // The arbiter is the slave of both requesters and drives the write port.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, conflict_cnt
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the execute
// (A) and load (B) writeback paths, with one registered output stage.
module regfile_wb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit DROP_ZERO = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  side_t             ptr;
  logic              both;
  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic              drop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign both = bus.a_valid & bus.b_valid;

  // Grants are gated by rst_n so neither requester sees ready while in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (bus.a_valid && (!bus.b_valid || ptr == SIDE_A)) grant_a = 1'b1;
      else if (bus.b_valid)                                grant_b = 1'b1;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign xfer        = grant_a | grant_b;
  assign sel_addr    = grant_a ? bus.a_addr : bus.b_addr;
  assign sel_data    = grant_a ? bus.a_data : bus.b_data;
  // A retired write to $0 is accepted but never reaches the register file.
  assign drop        = DROP_ZERO && (sel_addr == '0);

  // Contended transfers hand priority to the side that just lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ptr <= SIDE_A;
    end else if (xfer && both) begin
      ptr <= grant_a ? SIDE_B : SIDE_A;
    end
  end

  // Address/data only move on a real write, so they keep the last written values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= xfer && !drop;
      if (xfer && !drop) begin
        bus.wr_addr <= sel_addr;
        bus.wr_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.conflict_cnt <= '0;
    end else if (both && bus.conflict_cnt != CNT_MAX) begin
      bus.conflict_cnt <= bus.conflict_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: two arbiters (DROP_ZERO=1/CNT_W=16 and DROP_ZERO=0/CNT_W=4)
// share one stimulus stream; vectors carry hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;

  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_d ();
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_p ();

  assign bus_d.a_valid = a_valid;
  assign bus_d.a_addr  = a_addr;
  assign bus_d.a_data  = a_data;
  assign bus_d.b_valid = b_valid;
  assign bus_d.b_addr  = b_addr;
  assign bus_d.b_data  = b_data;
  assign bus_p.a_valid = a_valid;
  assign bus_p.a_addr  = a_addr;
  assign bus_p.a_data  = a_data;
  assign bus_p.b_valid = b_valid;
  assign bus_p.b_addr  = b_addr;
  assign bus_p.b_data  = b_data;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_ZERO(1'b1), .CNT_W(16)) dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d)
  );

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_ZERO(1'b0), .CNT_W(4)) dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file fed by the DROP_ZERO=1 write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (bus_d.wr_en) rf[bus_d.wr_addr] <= bus_d.wr_data;
  end

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        en_d;
    logic        en_p;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  initial begin
    //               av    aa     ad            bv    ba     bd        ar    br    en_d  en_p  wa     wd            cnt
    vecs[0]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB1,   1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1,       16'd1};
    vecs[1]  = '{1'b1, 5'd3, 32'hA2,       1'b1, 5'd2, 32'hB1,   1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'hB1,       16'd2};
    vecs[2]  = '{1'b1, 5'd3, 32'hA2,       1'b1, 5'd4, 32'hB2,   1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA2,       16'd3};
    vecs[3]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd4, 32'hB2,   1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'hB2,       16'd4};
    vecs[4]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 16'd4};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 16'd4};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234,     16'd4};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234,     16'd4};
    vecs[8]  = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55,       16'd4};
    vecs[9]  = '{1'b1, 5'd0, 32'h66,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h66,       16'd5};
    vecs[10] = '{1'b1, 5'd6, 32'h77,       1'b1, 5'd9, 32'h99,   1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99,       16'd6};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       16'd6};
    vecs[12] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,   1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h11,       16'd7};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h22,   1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h22,       16'd7};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h22,       16'd7};

    // Reset held with both requesters valid.
    rst_n = 1'b0;
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB1);
    repeat (3) @(posedge clk);
    #1;
    check("rst a_ready",  64'(bus_d.a_ready), 64'd0);
    check("rst b_ready",  64'(bus_d.b_ready), 64'd0);
    check("rst wr_en",    64'(bus_d.wr_en), 64'd0);
    check("rst wr_addr",  64'(bus_d.wr_addr), 64'd0);
    check("rst wr_data",  64'(bus_d.wr_data), 64'd0);
    check("rst cnt",      64'(bus_d.conflict_cnt), 64'd0);
    check("rst cnt p",    64'(bus_p.conflict_cnt), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #1;
      check($sformatf("v%0d a_ready", i),   64'(bus_d.a_ready), 64'(vecs[i].ar));
      check($sformatf("v%0d b_ready", i),   64'(bus_d.b_ready), 64'(vecs[i].br));
      check($sformatf("v%0d a_ready p", i), 64'(bus_p.a_ready), 64'(vecs[i].ar));
      check($sformatf("v%0d b_ready p", i), 64'(bus_p.b_ready), 64'(vecs[i].br));
      @(posedge clk);
      #1;
      check($sformatf("v%0d wr_en d", i),   64'(bus_d.wr_en), 64'(vecs[i].en_d));
      check($sformatf("v%0d wr_en p", i),   64'(bus_p.wr_en), 64'(vecs[i].en_p));
      check($sformatf("v%0d wr_addr p", i), 64'(bus_p.wr_addr), 64'(vecs[i].wa));
      check($sformatf("v%0d wr_data p", i), 64'(bus_p.wr_data), 64'(vecs[i].wd));
      if (vecs[i].en_d) begin
        check($sformatf("v%0d wr_addr d", i), 64'(bus_d.wr_addr), 64'(vecs[i].wa));
        check($sformatf("v%0d wr_data d", i), 64'(bus_d.wr_data), 64'(vecs[i].wd));
      end
      check($sformatf("v%0d cnt d", i), 64'(bus_d.conflict_cnt), 64'(vecs[i].cnt));
      check($sformatf("v%0d cnt p", i), 64'(bus_p.conflict_cnt), 64'(vecs[i].cnt[3:0]));
    end

    check("rf[7] last writer", 64'(rf[7]), 64'h22);
    check("rf[5]",             64'(rf[5]), 64'hDEADBEEF);

    // Long contention: pointer sits at B, grants alternate starting with B.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      #1;
      check($sformatf("sat%0d a_ready", i), 64'(bus_d.a_ready), 64'(i % 2 == 1));
      check($sformatf("sat%0d b_ready", i), 64'(bus_d.b_ready), 64'(i % 2 == 0));
      @(posedge clk);
      #1;
    end
    check("sat cnt d", 64'(bus_d.conflict_cnt), 64'd27);
    check("sat cnt p", 64'(bus_p.conflict_cnt), 64'd15);
    check("sat wr_en", 64'(bus_d.wr_en), 64'd1);
    check("sat wr_addr", 64'(bus_d.wr_addr), 64'd3);

    // Asynchronous reset pulse in the middle of a cycle with a write pending.
    #2;
    rst_n = 1'b0;
    #1;
    check("async wr_en d",   64'(bus_d.wr_en), 64'd0);
    check("async wr_en p",   64'(bus_p.wr_en), 64'd0);
    check("async cnt d",     64'(bus_d.conflict_cnt), 64'd0);
    check("async cnt p",     64'(bus_p.conflict_cnt), 64'd0);
    check("async a_ready",   64'(bus_d.a_ready), 64'd0);
    check("async b_ready",   64'(bus_d.b_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post-rst a_ready", 64'(bus_d.a_ready), 64'd1);
    check("post-rst b_ready", 64'(bus_d.b_ready), 64'd0);
    @(posedge clk);
    #1;
    check("post-rst wr_en",   64'(bus_d.wr_en), 64'd1);
    check("post-rst wr_addr", 64'(bus_d.wr_addr), 64'd3);
    check("post-rst wr_data", 64'(bus_d.wr_data), 64'h33);
    check("post-rst cnt",     64'(bus_d.conflict_cnt), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check("idle wr_en", 64'(bus_d.wr_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
